// File: rtl/rvi_bj_ex_ctrl.sv
// Shared RVI branch/jump execute controller for two issue requesters.
// Ports: req_* issue side, wb_* result pulse, rdrct_* fetch redirect.
module rvi_bj_ex_ctrl #(
    parameter int RV64      = 0,
    parameter int CPU_WIDTH = 32 * (RV64 + 1),
    parameter int TAG_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_vld,
    output logic [1:0]             req_rdy,
    input  logic [13:0]            req_op,
    input  logic [1:0]             req_unsigned,
    input  logic [3:0]             req_link_off,
    input  logic [2*CPU_WIDTH-1:0] req_pc,
    input  logic [2*CPU_WIDTH-1:0] req_s1,
    input  logic [2*CPU_WIDTH-1:0] req_s2,
    input  logic [2*CPU_WIDTH-1:0] req_offset,
    input  logic [2*TAG_W-1:0]     req_tag,
    input  logic                   flush,
    output logic                   wb_vld,
    output logic                   wb_taken,
    output logic [CPU_WIDTH-1:0]   wb_link,
    output logic [TAG_W-1:0]       wb_tag,
    output logic                   rdrct_vld,
    input  logic                   rdrct_rdy,
    output logic [CPU_WIDTH-1:0]   rdrct_addr,
    output logic [TAG_W-1:0]       rdrct_tag
);

    typedef enum logic {
        IDLE  = 1'b0,
        RDRCT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic rr;
    logic gnt_vld;
    logic gnt_sel;

    logic [6:0]           g_op;
    logic                 g_uns;
    logic [1:0]           g_lo;
    logic [CPU_WIDTH-1:0] g_pc;
    logic [CPU_WIDTH-1:0] g_s1;
    logic [CPU_WIDTH-1:0] g_s2;
    logic [CPU_WIDTH-1:0] g_off;
    logic [TAG_W-1:0]     g_tag;

    logic                 eq;
    logic                 lt;
    logic                 cond;
    logic                 g_taken;
    logic [CPU_WIDTH-1:0] jsum;
    logic [CPU_WIDTH-1:0] g_target;
    logic [CPU_WIDTH-1:0] g_link;

    // The branch class bit is implied by beq/bne/blt/bge.
    logic unused_branch;
    assign unused_branch = g_op[5];

    // Operand select for the granted requester.
    always_comb begin
        g_op  = gnt_sel ? req_op[13:7]       : req_op[6:0];
        g_uns = gnt_sel ? req_unsigned[1]    : req_unsigned[0];
        g_lo  = gnt_sel ? req_link_off[3:2]  : req_link_off[1:0];
        g_pc  = gnt_sel ? req_pc[2*CPU_WIDTH-1:CPU_WIDTH]
                        : req_pc[CPU_WIDTH-1:0];
        g_s1  = gnt_sel ? req_s1[2*CPU_WIDTH-1:CPU_WIDTH]
                        : req_s1[CPU_WIDTH-1:0];
        g_s2  = gnt_sel ? req_s2[2*CPU_WIDTH-1:CPU_WIDTH]
                        : req_s2[CPU_WIDTH-1:0];
        g_off = gnt_sel ? req_offset[2*CPU_WIDTH-1:CPU_WIDTH]
                        : req_offset[CPU_WIDTH-1:0];
        g_tag = gnt_sel ? req_tag[2*TAG_W-1:TAG_W]
                        : req_tag[TAG_W-1:0];
    end

    // Condition evaluation and target/link generation.
    always_comb begin
        eq   = (g_s1 == g_s2);
        lt   = g_uns ? (g_s1 < g_s2)
                     : ($signed(g_s1) < $signed(g_s2));
        cond = g_op[0]
             | (g_op[4] & eq)
             | (g_op[3] & ~eq)
             | (g_op[2] & lt)
             | (g_op[1] & ~lt);
        // bjEn gates every effect of the op.
        g_taken  = g_op[6] & cond;
        jsum     = g_s1 + g_off;
        g_target = g_op[0]
                 ? (jsum & ~{{(CPU_WIDTH-1){1'b0}}, 1'b1})
                 : (g_pc + g_off);
        g_link   = (g_op[6] & g_op[0])
                 ? (g_pc + {{(CPU_WIDTH-3){1'b0}}, g_lo, 1'b0})
                 : '0;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (gnt_vld && g_taken) state_nxt = RDRCT;
            RDRCT: if (rdrct_rdy) state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Outputs: round-robin grant, only while idle and not flushing.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_sel   = rr;
        req_rdy   = 2'b00;
        rdrct_vld = (state == RDRCT);
        if (state == IDLE && !flush && !rst) begin
            if (req_vld[rr]) begin
                gnt_vld = 1'b1;
                gnt_sel = rr;
            end else if (req_vld[~rr]) begin
                gnt_vld = 1'b1;
                gnt_sel = ~rr;
            end
        end
        if (gnt_vld) req_rdy[gnt_sel] = 1'b1;
    end

    // Result registers; redirect payload holds while pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr         <= 1'b0;
            wb_vld     <= 1'b0;
            wb_taken   <= 1'b0;
            wb_link    <= '0;
            wb_tag     <= '0;
            rdrct_addr <= '0;
            rdrct_tag  <= '0;
        end else begin
            wb_vld   <= gnt_vld;
            wb_taken <= gnt_vld & g_taken;
            wb_link  <= gnt_vld ? g_link : '0;
            wb_tag   <= gnt_vld ? g_tag : '0;
            if (gnt_vld) rr <= ~gnt_sel;
            if (gnt_vld && g_taken) begin
                rdrct_addr <= g_target;
                rdrct_tag  <= g_tag;
            end
        end
    end

endmodule

// File: tb/tb_rvi_bj_ex_ctrl.sv
// Testbench for rvi_bj_ex_ctrl: directed scenarios plus a randomized
// run against a behavioural model of arbitration, evaluation and redirect.
module tb_rvi_bj_ex_ctrl;

    localparam int W  = 32;
    localparam int TW = 4;

    localparam logic [6:0] OP_BEQ = 7'b1110000;
    localparam logic [6:0] OP_BNE = 7'b1101000;
    localparam logic [6:0] OP_BLT = 7'b1100100;
    localparam logic [6:0] OP_BGE = 7'b1100010;
    localparam logic [6:0] OP_JMP = 7'b1000001;

    logic          clk;
    logic          rst;
    logic [1:0]    req_vld;
    logic [1:0]    req_rdy;
    logic [13:0]   req_op;
    logic [1:0]    req_unsigned;
    logic [3:0]    req_link_off;
    logic [2*W-1:0] req_pc;
    logic [2*W-1:0] req_s1;
    logic [2*W-1:0] req_s2;
    logic [2*W-1:0] req_offset;
    logic [2*TW-1:0] req_tag;
    logic          flush;
    logic          wb_vld;
    logic          wb_taken;
    logic [W-1:0]  wb_link;
    logic [TW-1:0] wb_tag;
    logic          rdrct_vld;
    logic          rdrct_rdy;
    logic [W-1:0]  rdrct_addr;
    logic [TW-1:0] rdrct_tag;

    rvi_bj_ex_ctrl #(
        .RV64(0),
        .CPU_WIDTH(W),
        .TAG_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_vld(req_vld),
        .req_rdy(req_rdy),
        .req_op(req_op),
        .req_unsigned(req_unsigned),
        .req_link_off(req_link_off),
        .req_pc(req_pc),
        .req_s1(req_s1),
        .req_s2(req_s2),
        .req_offset(req_offset),
        .req_tag(req_tag),
        .flush(flush),
        .wb_vld(wb_vld),
        .wb_taken(wb_taken),
        .wb_link(wb_link),
        .wb_tag(wb_tag),
        .rdrct_vld(rdrct_vld),
        .rdrct_rdy(rdrct_rdy),
        .rdrct_addr(rdrct_addr),
        .rdrct_tag(rdrct_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: round-robin pointer and pending redirect.
    bit            m_rr;
    bit            m_pend;
    logic [W-1:0]  m_addr;
    logic [TW-1:0] m_tag;

    // Bench copy of what was driven, per requester.
    logic [6:0]    d_op  [2];
    logic          d_uns [2];
    logic [1:0]    d_lo  [2];
    logic [W-1:0]  d_pc  [2];
    logic [W-1:0]  d_s1  [2];
    logic [W-1:0]  d_s2  [2];
    logic [W-1:0]  d_off [2];
    logic [TW-1:0] d_tag [2];

    // Reference: arithmetic on wide integers, wrapped to 2^32.
    function automatic void ref_eval(
        input  logic [6:0] op,
        input  logic       uns,
        input  logic [1:0] lo,
        input  logic [W-1:0] pc,
        input  logic [W-1:0] s1,
        input  logic [W-1:0] s2,
        input  logic [W-1:0] off,
        output bit         tk,
        output logic [W-1:0] tgt,
        output logic [W-1:0] lnk
    );
        longint unsigned m;
        longint unsigned sum;
        bit en;
        bit jmp;
        bit eq;
        bit lt;
        m   = 64'h1_0000_0000;
        en  = op[6];
        jmp = op[0];
        eq  = (s1 == s2);
        if (uns) lt = longint'(s1) < longint'(s2);
        else lt = longint'($signed(s1)) < longint'($signed(s2));
        tk = en && (jmp || (op[4] && eq) || (op[3] && !eq)
             || (op[2] && lt) || (op[1] && !lt));
        if (jmp) begin
            sum = (longint'(s1) + longint'(off)) % m;
            sum = sum - (sum % 2);
        end else begin
            sum = (longint'(pc) + longint'(off)) % m;
        end
        tgt = sum[W-1:0];
        if (en && jmp) begin
            sum = (longint'(pc) + 2 * longint'(lo)) % m;
            lnk = sum[W-1:0];
        end else begin
            lnk = '0;
        end
    endfunction

    task automatic put(
        input int r,
        input logic [6:0] op,
        input logic uns,
        input logic [1:0] lo,
        input logic [W-1:0] pc,
        input logic [W-1:0] s1,
        input logic [W-1:0] s2,
        input logic [W-1:0] off,
        input logic [TW-1:0] tag
    );
        req_op[7*r +: 7]        = op;
        req_unsigned[r]         = uns;
        req_link_off[2*r +: 2]  = lo;
        req_pc[W*r +: W]        = pc;
        req_s1[W*r +: W]        = s1;
        req_s2[W*r +: W]        = s2;
        req_offset[W*r +: W]    = off;
        req_tag[TW*r +: TW]     = tag;
        d_op[r]  = op;
        d_uns[r] = uns;
        d_lo[r]  = lo;
        d_pc[r]  = pc;
        d_s1[r]  = s1;
        d_s2[r]  = s2;
        d_off[r] = off;
        d_tag[r] = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        rdrct_rdy = 1'b1;
        tick();
        rdrct_rdy = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_vld = 2'b11;
        put(0, OP_JMP, 0, 2'b10, 32'h100, 32'h10, 0, 4, 1);
        put(1, OP_JMP, 0, 2'b10, 32'h200, 32'h20, 0, 4, 2);
        #3;
        n_checks++; if (req_rdy !== 2'b00) $display("FAIL rst_rdy: got %b want 00", req_rdy); else n_pass++;
        tick();
        tick();
        n_checks++; if (wb_vld !== 1'b0) $display("FAIL rst_wb_vld: got %b want 0", wb_vld); else n_pass++;
        n_checks++; if (wb_taken !== 1'b0) $display("FAIL rst_wb_taken: got %b want 0", wb_taken); else n_pass++;
        n_checks++; if (wb_link !== '0) $display("FAIL rst_wb_link: got %h want 0", wb_link); else n_pass++;
        n_checks++; if (wb_tag !== '0) $display("FAIL rst_wb_tag: got %h want 0", wb_tag); else n_pass++;
        n_checks++; if (rdrct_vld !== 1'b0) $display("FAIL rst_rdrct_vld: got %b want 0", rdrct_vld); else n_pass++;
        n_checks++; if (rdrct_addr !== '0) $display("FAIL rst_rdrct_addr: got %h want 0", rdrct_addr); else n_pass++;
        n_checks++; if (rdrct_tag !== '0) $display("FAIL rst_rdrct_tag: got %h want 0", rdrct_tag); else n_pass++;
        req_vld = 2'b00;
        rst = 1'b0;
        m_rr = 1'b0;
        m_pend = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        bit g;
        logic [1:0] exp_rdy;
        for (int i = 0; i < 4; i++) begin
            put(0, OP_BEQ, 0, 0, 32'h40, 1, 2, 8, TW'(2*i));
            put(1, OP_BEQ, 0, 0, 32'h80, 1, 2, 8, TW'(2*i+1));
            req_vld = 2'b11;
            g = m_rr;
            exp_rdy = g ? 2'b10 : 2'b01;
            #1;
            n_checks++; if (req_rdy !== exp_rdy) $display("FAIL rr_grant%0d: got %b want %b", i, req_rdy, exp_rdy); else n_pass++;
            tick();
            m_rr = !g;
            n_checks++; if (wb_vld !== 1'b1) $display("FAIL rr_wb_vld%0d: got %b want 1", i, wb_vld); else n_pass++;
            n_checks++; if (wb_taken !== 1'b0) $display("FAIL rr_taken%0d: got %b want 0", i, wb_taken); else n_pass++;
            n_checks++; if (wb_tag !== d_tag[g]) $display("FAIL rr_tag%0d: got %h want %h", i, wb_tag, d_tag[g]); else n_pass++;
        end
        req_vld = 2'b00;
        tick();
        n_checks++; if (wb_vld !== 1'b0) $display("FAIL rr_idle_wb: got %b want 0", wb_vld); else n_pass++;
    endtask

    task automatic test_jump();
        int r;
        r = m_rr;
        put(r, OP_JMP, 0, 2'b10, 32'h100, 32'h203, 0, 4, 5);
        req_vld = 2'b00;
        req_vld[r] = 1'b1;
        tick();
        req_vld = 2'b00;
        m_rr = !r;
        n_checks++; if (wb_vld !== 1'b1) $display("FAIL jmp_wb_vld: got %b want 1", wb_vld); else n_pass++;
        n_checks++; if (wb_taken !== 1'b1) $display("FAIL jmp_taken: got %b want 1", wb_taken); else n_pass++;
        n_checks++; if (wb_link !== 32'h104) $display("FAIL jmp_link: got %h want 00000104", wb_link); else n_pass++;
        n_checks++; if (rdrct_vld !== 1'b1) $display("FAIL jmp_rdrct_vld: got %b want 1", rdrct_vld); else n_pass++;
        n_checks++; if (rdrct_addr !== 32'h206) $display("FAIL jmp_addr: got %h want 00000206", rdrct_addr); else n_pass++;
        n_checks++; if (rdrct_tag !== 4'd5) $display("FAIL jmp_tag: got %h want 5", rdrct_tag); else n_pass++;
        accept();
        n_checks++; if (rdrct_vld !== 1'b0) $display("FAIL jmp_accept: got %b want 0", rdrct_vld); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        int r;
        int o;
        logic [1:0] exp_rdy;
        r = m_rr;
        o = 1 - r;
        put(r, OP_BNE, 0, 0, 32'h400, 5, 6, 32'h20, 9);
        put(o, OP_BEQ, 0, 0, 32'h500, 1, 2, 32'h20, 3);
        req_vld = 2'b00;
        req_vld[r] = 1'b1;
        tick();
        m_rr = (r == 0);
        req_vld = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rdrct_rdy = 1'b1;
            n_checks++; if (rdrct_vld !== 1'b1) $display("FAIL hold_vld%0d: got %b want 1", i, rdrct_vld); else n_pass++;
            n_checks++; if (rdrct_addr !== 32'h420) $display("FAIL hold_addr%0d: got %h want 00000420", i, rdrct_addr); else n_pass++;
            #1;
            n_checks++; if (req_rdy !== 2'b00) $display("FAIL hold_rdy%0d: got %b want 00", i, req_rdy); else n_pass++;
            tick();
        end
        rdrct_rdy = 1'b0;
        m_pend = 1'b0;
        n_checks++; if (rdrct_vld !== 1'b0) $display("FAIL hold_release: got %b want 0", rdrct_vld); else n_pass++;
        // r was granted last, so the other requester wins now.
        exp_rdy = (o == 1) ? 2'b10 : 2'b01;
        #1;
        n_checks++; if (req_rdy !== exp_rdy) $display("FAIL hold_regrant: got %b want %b", req_rdy, exp_rdy); else n_pass++;
        tick();
        req_vld = 2'b00;
        m_rr = (o == 0);
        n_checks++; if (wb_tag !== 4'd3) $display("FAIL hold_next_tag: got %h want 3", wb_tag); else n_pass++;
    endtask

    task automatic test_blt_sign();
        int r;
        for (int s = 0; s < 2; s++) begin
            r = m_rr;
            put(r, OP_BLT, (s == 0), 0, 32'h1000, 32'hFFFF_FFFF, 1, 32'h40, TW'(s + 2));
            req_vld = 2'b00;
            req_vld[r] = 1'b1;
            tick();
            req_vld = 2'b00;
            m_rr = (r == 0);
            n_checks++; if (wb_taken !== (s == 1)) $display("FAIL blt_taken_s%0d: got %b want %b", s, wb_taken, (s == 1)); else n_pass++;
            n_checks++; if (rdrct_vld !== (s == 1)) $display("FAIL blt_rdrct_s%0d: got %b want %b", s, rdrct_vld, (s == 1)); else n_pass++;
        end
        n_checks++; if (rdrct_addr !== 32'h1040) $display("FAIL blt_addr: got %h want 00001040", rdrct_addr); else n_pass++;
        accept();
    endtask

    task automatic test_wrap();
        int r;
        r = m_rr;
        put(r, OP_BEQ, 0, 0, 32'hFFFF_FFFC, 7, 7, 8, 6);
        req_vld = 2'b00;
        req_vld[r] = 1'b1;
        tick();
        req_vld = 2'b00;
        m_rr = (r == 0);
        n_checks++; if (wb_link !== '0) $display("FAIL wrap_link: got %h want 0", wb_link); else n_pass++;
        n_checks++; if (rdrct_addr !== 32'h4) $display("FAIL wrap_addr: got %h want 00000004", rdrct_addr); else n_pass++;
        accept();
    endtask

    task automatic test_flush();
        int r;
        logic [1:0] exp_rdy;
        put(0, OP_BEQ, 0, 0, 32'h10, 1, 2, 4, 1);
        put(1, OP_BEQ, 0, 0, 32'h20, 1, 2, 4, 2);
        req_vld = 2'b11;
        flush = 1'b1;
        #1;
        n_checks++; if (req_rdy !== 2'b00) $display("FAIL flush_rdy: got %b want 00", req_rdy); else n_pass++;
        tick();
        flush = 1'b0;
        n_checks++; if (wb_vld !== 1'b0) $display("FAIL flush_wb: got %b want 0", wb_vld); else n_pass++;
        exp_rdy = m_rr ? 2'b10 : 2'b01;
        #1;
        n_checks++; if (req_rdy !== exp_rdy) $display("FAIL flush_rr_kept: got %b want %b", req_rdy, exp_rdy); else n_pass++;
        tick();
        req_vld = 2'b00;
        m_rr = !m_rr;
        r = m_rr;
        put(r, OP_JMP, 0, 2'b01, 32'h300, 32'h500, 0, 0, 7);
        req_vld[r] = 1'b1;
        tick();
        req_vld = 2'b00;
        m_rr = (r == 0);
        n_checks++; if (rdrct_vld !== 1'b1) $display("FAIL flush_setup: got %b want 1", rdrct_vld); else n_pass++;
        flush = 1'b1;
        rdrct_rdy = 1'b1;
        tick();
        flush = 1'b0;
        rdrct_rdy = 1'b0;
        n_checks++; if (rdrct_vld !== 1'b0) $display("FAIL flush_drop: got %b want 0", rdrct_vld); else n_pass++;
        n_checks++; if (wb_vld !== 1'b0) $display("FAIL flush_drop_wb: got %b want 0", wb_vld); else n_pass++;
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] op;
        case ($urandom % 6)
            0: op = OP_BEQ;
            1: op = OP_BNE;
            2: op = OP_BLT;
            3: op = OP_BGE;
            4: op = OP_JMP;
            default: op = {1'b0, 6'($urandom)};
        endcase
        return op;
    endfunction

    task automatic test_random();
        int g;
        bit e_tk;
        logic [W-1:0] e_tgt;
        logic [W-1:0] e_lnk;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic [1:0] exp_rdy;
        bit rdy;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                s1 = $urandom;
                s2 = ($urandom % 3 == 0) ? s1 : $urandom;
                put(r, rand_op(), 1'($urandom), 2'($urandom),
                    $urandom, s1, s2,
                    32'($urandom_range(0, 8191)) - 32'd4096,
                    TW'($urandom));
            end
            req_vld = 2'($urandom);
            flush = ($urandom % 16 == 0);
            rdy = ($urandom % 3 == 0);
            rdrct_rdy = rdy;
            g = -1;
            if (!m_pend && !flush) begin
                if (req_vld[m_rr]) g = m_rr;
                else if (req_vld[!m_rr]) g = !m_rr;
            end
            exp_rdy = 2'b00;
            e_tk = 0;
            e_tgt = '0;
            e_lnk = '0;
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                ref_eval(d_op[g], d_uns[g], d_lo[g], d_pc[g],
                         d_s1[g], d_s2[g], d_off[g],
                         e_tk, e_tgt, e_lnk);
            end
            #1;
            n_checks++; if (req_rdy !== exp_rdy) $display("FAIL rnd_rdy c%0d: got %b want %b", c, req_rdy, exp_rdy); else n_pass++;
            tick();
            n_checks++; if (wb_vld !== (g >= 0)) $display("FAIL rnd_wb_vld c%0d: got %b want %b", c, wb_vld, (g >= 0)); else n_pass++;
            if (g >= 0) begin
                n_checks++; if (wb_taken !== e_tk) $display("FAIL rnd_taken c%0d: got %b want %b", c, wb_taken, e_tk); else n_pass++;
                n_checks++; if (wb_link !== e_lnk) $display("FAIL rnd_link c%0d: got %h want %h", c, wb_link, e_lnk); else n_pass++;
                n_checks++; if (wb_tag !== d_tag[g]) $display("FAIL rnd_tag c%0d: got %h want %h", c, wb_tag, d_tag[g]); else n_pass++;
                m_rr = (g == 0);
            end
            if (flush) begin
                m_pend = 1'b0;
            end else if (g >= 0 && e_tk) begin
                m_pend = 1'b1;
                m_addr = e_tgt;
                m_tag = d_tag[g];
            end else if (m_pend && rdy) begin
                m_pend = 1'b0;
            end
            n_checks++; if (rdrct_vld !== m_pend) $display("FAIL rnd_rdrct c%0d: got %b want %b", c, rdrct_vld, m_pend); else n_pass++;
            if (m_pend) begin
                n_checks++; if (rdrct_addr !== m_addr) $display("FAIL rnd_addr c%0d: got %h want %h", c, rdrct_addr, m_addr); else n_pass++;
                n_checks++; if (rdrct_tag !== m_tag) $display("FAIL rnd_rtag c%0d: got %h want %h", c, rdrct_tag, m_tag); else n_pass++;
            end
        end
        req_vld = 2'b00;
        rdrct_rdy = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic test_async_reset();
        int r;
        r = m_rr;
        put(r, OP_JMP, 0, 2'b10, 32'h700, 32'h900, 0, 0, 4);
        req_vld = 2'b00;
        req_vld[r] = 1'b1;
        tick();
        req_vld = 2'b11;
        n_checks++; if (rdrct_vld !== 1'b1) $display("FAIL arst_setup: got %b want 1", rdrct_vld); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (wb_vld !== 1'b0) $display("FAIL arst_wb_vld: got %b want 0", wb_vld); else n_pass++;
        n_checks++; if (wb_link !== '0) $display("FAIL arst_wb_link: got %h want 0", wb_link); else n_pass++;
        n_checks++; if (rdrct_vld !== 1'b0) $display("FAIL arst_rdrct_vld: got %b want 0", rdrct_vld); else n_pass++;
        n_checks++; if (rdrct_addr !== '0) $display("FAIL arst_addr: got %h want 0", rdrct_addr); else n_pass++;
        n_checks++; if (req_rdy !== 2'b00) $display("FAIL arst_rdy: got %b want 00", req_rdy); else n_pass++;
        req_vld = 2'b00;
        tick();
        rst = 1'b0;
        m_rr = 1'b0;
        m_pend = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req_vld = '0;
        req_op = '0;
        req_unsigned = '0;
        req_link_off = '0;
        req_pc = '0;
        req_s1 = '0;
        req_s2 = '0;
        req_offset = '0;
        req_tag = '0;
        flush = 1'b0;
        rdrct_rdy = 1'b0;
        m_rr = 1'b0;
        m_pend = 1'b0;
        m_addr = '0;
        m_tag = '0;
        test_reset();
        test_round_robin();
        test_jump();
        test_redirect_hold();
        test_blt_sign();
        test_wrap();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
